frame_sequencer: RTL
====================

# frame_sequencer

Sequences one Ethernet-style transmit frame from the 48-byte message ROM (`buffer`) into the RGMII transmit path. On a start pulse it emits 7 preamble bytes (0x55), one SFD byte (0xD5), then MSG_LEN payload bytes read from the ROM at addresses 0..MSG_LEN-1, then holds an inter-frame gap. Output is a registered byte stream with a valid/ready handshake. The block sits between the ROM and the RGMII DDR transmitter.

## Interface
- MSG_LEN, 48: payload bytes per frame, 1..64
- PREAMBLE_LEN, 7: number of 0x55 bytes before SFD, ≥1
- IFG_LEN, 12: idle cycles after last payload transfer, ≥1
- ADDR_W, 6: ROM address width
- clk  in  1  sole clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  frame request; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted through the last IFG cycle
- done  out  1  one-cycle pulse on return to IDLE after a frame
- rom_addr  out  ADDR_W  ROM address, combinational from payload counter
- rom_data  in  8  ROM data, combinational from rom_addr
- tx_data  out  8  byte presented to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte; transfer = tx_valid && tx_ready at an edge
- tx_sof  out  1  high with the first preamble byte
- tx_eof  out  1  high with the last payload byte

## Operation
- States: IDLE, PREAMBLE, SFD, PAYLOAD, GAP.
- IDLE: start=1 → PREAMBLE; preamble counter and payload counter cleared.
- Output register (tx_data, tx_valid, tx_sof, tx_eof) loads when !tx_valid || tx_ready; otherwise holds all four unchanged (no byte change while stalled).
- PREAMBLE: loads 0x55 PREAMBLE_LEN times; tx_sof=1 on the first only; after the last load → SFD.
- SFD: loads 0xD5 once → PAYLOAD.
- PAYLOAD: loads rom_data at rom_addr = payload counter, counter increments per load; tx_eof=1 when counter = MSG_LEN-1; after that load → GAP once the last byte transfers.
- GAP: tx_valid=0; counts IFG_LEN cycles → IDLE with done=1 for that one cycle.
- start outside IDLE is ignored (not queued). start in the IDLE cycle that carries done is accepted.
- rom_addr holds 0 in IDLE; counters never exceed MSG_LEN-1 (no wrap into unused ROM space).
- rst=1 at any edge: state IDLE, counters 0, all outputs at reset values regardless of tx_ready; an in-flight frame is abandoned with no eof.

## Timing
- Reset values: busy=0, done=0, tx_valid=0, tx_data=0x00, tx_sof=0, tx_eof=0, rom_addr=0.
- start sampled at edge N → tx_valid=1, tx_data=0x55, tx_sof=1 after edge N+1; busy=1 after edge N.
- With tx_ready held 1: one byte per cycle, PREAMBLE_LEN+1+MSG_LEN consecutive beats (56 at defaults).
- GAP begins the cycle after the eof transfer; tx_valid=0 for exactly IFG_LEN cycles; done high in the following cycle with busy=0.
- Start-to-done at full rate, defaults: 1+56+12 = 69 cycles from accepting edge to done cycle.
- Backpressure adds exactly one cycle per stalled cycle; no byte lost or duplicated.

## Structure
- Shared package `rgmii_pkg`: PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, state enum type.
- No sub-module inside; ROM `buffer` instantiated alongside at the top level and wired via rom_addr/rom_data.
- One FSM, one shared down/up counter reused for preamble/payload/gap, one output register stage.

## Test plan
- Defaults, tx_ready=1, start pulse → 7×0x55 (sof on first), 0xD5, 0x57 0x68 0x61 … 0x0d 0x0a (eof on 0x0a), 56 consecutive beats, 12 idle, done pulse.
- tx_ready toggled pseudo-randomly → identical 56-byte sequence, tx_data stable whenever valid&&!ready, total time +stall count.
- start re-pulsed during PAYLOAD → ignored; exactly one frame, one done.
- rst asserted at payload byte 10 (0x76) → next cycle tx_valid=0, busy=0, no eof; subsequent start gives full frame from 0x55.
- start held high continuously → frames back-to-back, each separated by exactly 12 idle cycles, done on each IDLE entry.
- MSG_LEN=4, PREAMBLE_LEN=1 → 0x55, 0xD5, 0x57 0x68 0x61 0x74 (eof), rom_addr never exceeds 3.

Source files
------------

// File: rtl/frame_sequencer_pkg.sv
// rgmii_pkg: constants and types shared by the RGMII transmit-side blocks.
//   PREAMBLE_BYTE / SFD_BYTE : fixed frame-header byte values
//   seq_state_t              : frame_sequencer FSM states
//   max3                     : elaboration-time helper for counter sizing
package rgmii_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_PAYLOAD,
    ST_GAP
  } seq_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if: byte stream from the sequencer to the RGMII transmitter.
//   tx_data  : byte presented
//   tx_valid : tx_data is valid
//   tx_ready : transmitter accepts (transfer = tx_valid && tx_ready at an edge)
//   tx_sof   : first preamble byte of a frame
//   tx_eof   : last payload byte of a frame
// master = byte source (sequencer), slave = byte sink (transmitter).
interface frame_sequencer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_sof;
  logic       tx_eof;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_sof,
    output tx_eof,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_sof,
    input  tx_eof,
    output tx_ready
  );

endinterface

// File: rtl/frame_sequencer.sv
// frame_sequencer: on a start pulse emits PREAMBLE_LEN x 0x55, one 0xD5, then
// MSG_LEN payload bytes read from the message ROM, then holds IFG_LEN idle
// cycles before returning to IDLE with a one-cycle done pulse.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : frame request, only honoured in IDLE
//   busy      : frame in progress (PREAMBLE through last GAP cycle)
//   done      : one-cycle pulse on return to IDLE
//   rom_addr  : ROM address (payload counter in PAYLOAD, 0 otherwise)
//   rom_data  : ROM data for rom_addr
//   tx        : registered byte stream with valid/ready handshake
module frame_sequencer
  import rgmii_pkg::*;
#(
  parameter int MSG_LEN      = 48,
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_LEN      = 12,
  parameter int ADDR_W       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  frame_sequencer_if.master tx
);

  // One counter is shared by the preamble, payload and gap phases, so it is
  // sized for the longest of the three.
  localparam int CNT_W = $clog2(max3(MSG_LEN, PREAMBLE_LEN, IFG_LEN) + 1);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_LEN - 1);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_LEN - 1);

  seq_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic [7:0]       data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             sof_reg, sof_next;
  logic             eof_reg, eof_next;
  logic             ld;

  always_comb begin
    // The output register may take a new value only when it is empty or its
    // current byte is being accepted; otherwise all four fields hold.
    ld         = !valid_reg || tx.tx_ready;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    data_next  = data_reg;
    valid_next = valid_reg;
    sof_next   = sof_reg;
    eof_next   = eof_reg;

    if (ld) begin
      data_next  = 8'h00;
      valid_next = 1'b0;
      sof_next   = 1'b0;
      eof_next   = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_PREAMBLE;
          cnt_next   = '0;
        end
      end

      ST_PREAMBLE: begin
        if (ld) begin
          data_next  = PREAMBLE_BYTE;
          valid_next = 1'b1;
          sof_next   = (cnt_reg == '0);
          if (cnt_reg == PRE_LAST) begin
            state_next = ST_SFD;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      ST_SFD: begin
        if (ld) begin
          data_next  = SFD_BYTE;
          valid_next = 1'b1;
          state_next = ST_PAYLOAD;
          cnt_next   = '0;
        end
      end

      ST_PAYLOAD: begin
        if (ld) begin
          if (eof_reg) begin
            // Last byte is leaving now; the output empties into the gap.
            state_next = ST_GAP;
            cnt_next   = '0;
          end else begin
            data_next  = rom_data;
            valid_next = 1'b1;
            eof_next   = (cnt_reg == MSG_LAST);
            // Park on the last address rather than stepping past the message.
            if (cnt_reg != MSG_LAST) begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
      end

      ST_GAP: begin
        if (cnt_reg == IFG_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      data_reg  <= 8'h00;
      valid_reg <= 1'b0;
      sof_reg   <= 1'b0;
      eof_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      sof_reg   <= sof_next;
      eof_reg   <= eof_next;
    end
  end

  assign busy        = (state_reg != ST_IDLE);
  assign done        = done_reg;
  assign rom_addr    = (state_reg == ST_PAYLOAD) ? ADDR_W'(cnt_reg) : '0;
  assign tx.tx_data  = data_reg;
  assign tx.tx_valid = valid_reg;
  assign tx.tx_sof   = sof_reg;
  assign tx.tx_eof   = eof_reg;

endmodule
